seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Parametrised, time-multiplexed driver for an N-digit common-anode/cathode 7-segment display. Accepts a packed BCD/hex word plus per-digit decimal points, double-buffers it, and scans one digit per refresh tick. It adds leading-zero blanking, selectable output polarity and a frame-done strobe. It sits between the numeric datapath (counters, ALU results) and the board display pins.

## Interface
- N_DIGITS, 4, number of multiplexed digits (1..8)
- DIV, 50000, clock cycles per digit slot (≥1)
- HEX_EN, 0, 1 = codes 10..15 render A,b,C,d,E,F; 0 = render blank
- SEG_ACTIVE_LOW, 0, 1 = seg/dp outputs inverted at the pins
- AN_ACTIVE_LOW, 1, 1 = an outputs active-low
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- digits_in  in  4*N_DIGITS  packed codes; digit 0 = bits [3:0] = least significant
- dp_in  in  N_DIGITS  decimal point per digit
- load  in  1  capture digits_in/dp_in into pending buffer
- lz_blank_en  in  1  enable leading-zero blanking
- en  in  1  scan enable
- seg  out  7  {a,b,c,d,e,f,g}
- dp  out  1  decimal point
- an  out  N_DIGITS  digit selects, one-hot when active
- frame_done  out  1  one-cycle pulse at scan wrap N_DIGITS-1 → 0

## Operation
- Segment table, active-high, before polarity: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B; HEX_EN: A=77 b=1F C=4E d=3D E=4F F=47; otherwise 10..15 = 00.
- Buffers: pending (codes+dp) written on any cycle with load=1. Active buffer drives the display.
- pending→active copy: at every frame boundary (same edge idx wraps to 0); additionally every cycle while en=0.
- Prescaler counts 0..DIV-1 while en=1; tick when count = DIV-1, count returns to 0.
- Scan index idx: 0..N_DIGITS-1, advances on tick, wraps to 0; frame_done asserted the cycle after the wrap edge for exactly one cycle.
- Leading-zero blanking: when lz_blank_en=1, digit k (k≥1) is blanked if it and every more-significant digit equal 0. Digit 0 is never blanked. Blanked digit: seg=00 but dp still honoured.
- en=0: prescaler and idx hold, an all inactive, seg/dp inactive; on en=1 scan resumes from held idx and count.

## Timing
- Reset (async assert, sync release): count=0, idx=0, pending=0, active=0, seg/dp inactive level, an all inactive, frame_done=0.
- seg, dp and an are registered: they reflect idx/active with exactly 1-cycle latency. Outputs are glitch-free.
- Each digit is driven for exactly DIV cycles; frame period = N_DIGITS*DIV cycles.
- load on the boundary edge: copy uses old pending. The new value appears on the following frame.
- DIV=1: idx advances every cycle. N_DIGITS=1: every tick is a boundary, and frame_done pulses every DIV cycles.
- load while en=0 is visible 1 cycle after en rises, because active is already copied.
- rst_n low mid-frame: all state is cleared immediately and outputs go inactive asynchronously.

## Structure
- Package seg7_pkg: the 16 segment constants, SEG_BLANK, and a decode function (code, hex_en) → 7 bits.
- Sub-module bcd_seg_decode: combinational code+blank+dp → seg/dp, active-high. The top applies polarity.
- Top holds the prescaler, idx, both buffers, LZ-blank mask logic and output registers.

## Test plan
- Reset then en=1, N_DIGITS=4, DIV=4, load 0x1234 → before the first frame, all 4 digits show 7E (active=0). After frame_done, digit0 shows 33 and an=1110 (active-low) for 4 cycles, then digit1 shows 79.
- lz_blank_en=1, load 0x0050 → digits 3,2 show 00; digit1=5B; digit0=7E. Load 0x0000 → only digit 0 lit with 7E.
- HEX_EN=0 with code 0xA → 00. HEX_EN=1 → 77. SEG_ACTIVE_LOW=1 inverts to 08.
- load asserted exactly on the boundary edge with 0x9999 → next frame still shows the prior value. The following frame shows 7B on all digits.
- en dropped mid-slot at idx=2, count=1 → an and seg inactive. Re-assert → digit 2 resumes and completes its remaining 3 cycles.
- rst_n pulsed low mid-frame → outputs go inactive without waiting for a clock edge. After release, idx=0 and frame_done=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared segment constants and code-to-segment decode for the 7-segment scan driver.
// Segment order is {a,b,c,d,e,f,g}; all values are active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic [3:0] code;
        logic       blank;
        logic       dp;
    } digit_req_t;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
    } digit_rsp_t;

    // Codes 10..15 render as letters only when hex_en is set, otherwise dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic hex_en);
        logic [6:0] s;
        s = SEG_BLANK;
        case (code)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = hex_en ? SEG_A : SEG_BLANK;
            4'hB: s = hex_en ? SEG_B : SEG_BLANK;
            4'hC: s = hex_en ? SEG_C : SEG_BLANK;
            4'hD: s = hex_en ? SEG_D : SEG_BLANK;
            4'hE: s = hex_en ? SEG_E : SEG_BLANK;
            4'hF: s = hex_en ? SEG_F : SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Per-digit combinational decode: code + blank + dp -> active-high segments and dp.
// A blanked digit goes dark but keeps its decimal point.
module bcd_seg_decode
    import seg7_pkg::*;
#(
    parameter int HEX_EN = 0
) (
    input  digit_req_t req,
    output digit_rsp_t rsp
);

    always_comb begin
        rsp.seg = req.blank ? SEG_BLANK : seg_decode(req.code, HEX_EN != 0);
        rsp.dp  = req.dp;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: double-buffered codes, one digit per
// DIV-cycle slot, leading-zero blanking, pin polarity control and a frame-done pulse.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int DIV            = 50000,
    parameter int HEX_EN         = 0,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    load,
    input  logic                    lz_blank_en,
    input  logic                    en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int                  IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int                  CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(DIV - 1);
    localparam logic                SEG_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic                AN_INV   = (AN_ACTIVE_LOW != 0);
    // Inactive pin levels double as the XOR masks that apply polarity.
    localparam logic [6:0]          SEG_OFF  = {7{SEG_INV}};
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AN_INV}};

    logic [CNT_W-1:0]         count;
    logic [IDX_W-1:0]         idx;
    logic                     tick;
    logic                     wrap;
    logic [N_DIGITS-1:0][3:0] pend_code;
    logic [N_DIGITS-1:0][3:0] act_code;
    logic [N_DIGITS-1:0]      pend_dp;
    logic [N_DIGITS-1:0]      act_dp;
    logic [N_DIGITS-1:0]      digit_sel;
    digit_req_t [N_DIGITS-1:0] req;
    digit_rsp_t [N_DIGITS-1:0] rsp;
    digit_rsp_t               cur;

    assign tick = en && (count == LAST_CNT);
    assign wrap = tick && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            idx   <= '0;
        end else if (tick) begin
            count <= '0;
            idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
        end
    end

    // The copy samples the old pending value, so a load on the wrap edge waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_code <= '0;
            pend_dp   <= '0;
            act_code  <= '0;
            act_dp    <= '0;
        end else begin
            if (load) begin
                pend_code <= digits_in;
                pend_dp   <= dp_in;
            end
            if (wrap || !en) begin
                act_code <= pend_code;
                act_dp   <= pend_dp;
            end
        end
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
        logic blank_k;
        if (k == 0) begin : g_lsd
            assign blank_k = 1'b0;
        end else begin : g_upper
            // Dark when this digit and everything more significant is zero.
            assign blank_k = lz_blank_en && ~|act_code[N_DIGITS-1:k];
        end
        assign req[k] = '{code: act_code[k], blank: blank_k, dp: act_dp[k]};
        bcd_seg_decode #(.HEX_EN(HEX_EN)) u_dec (
            .req (req[k]),
            .rsp (rsp[k])
        );
    end

    always_comb begin
        cur       = '0;
        digit_sel = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur          = rsp[k];
                digit_sel[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            dp  <= SEG_INV;
            an  <= AN_OFF;
        end else if (en) begin
            seg <= cur.seg ^ SEG_OFF;
            dp  <= cur.dp ^ SEG_INV;
            an  <= digit_sel ^ AN_OFF;
        end else begin
            seg <= SEG_OFF;
            dp  <= SEG_INV;
            an  <= AN_OFF;
        end
    end

endmodule
